// File: rtl/comparator_pkg.sv
// Shared definitions for the serial comparator controller: FSM encodings,
// result-flag bit positions and a width helper.
package comparator_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COMPARE = 2'b01;
    localparam logic [1:0] DONE    = 2'b10;

    // Bit positions inside the one-hot result vector
    localparam int RES_GT = 0;
    localparam int RES_LT = 1;
    localparam int RES_EQ = 2;
    localparam int RES_W  = 3;

    // Bit-index width; a 1-bit operand still needs a 1-bit index register
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_comparator_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// serial comparator controller (slave).
interface serial_comparator_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_greater_B;
    logic             A_less_B;
    logic             A_equal_B;
    logic [CNT_W-1:0] bits_used;

    modport master (
        output start, A, B,
        input  busy, done, A_greater_B, A_less_B, A_equal_B, bits_used
    );

    modport slave (
        input  start, A, B,
        output busy, done, A_greater_B, A_less_B, A_equal_B, bits_used
    );

endinterface

// File: rtl/comparator_1bit.sv
// Combinational 1-bit magnitude comparator cell shared by the serial controller.
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// MSB-first bit-serial magnitude comparator: one shared 1-bit cell,
// one bit per clock, optional early exit at the first differing bit.
module serial_comparator_ctrl
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_comparator_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_reg,     state_next;
    logic [WIDTH-1:0] a_sh_reg,      a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,      b_sh_next;
    logic [IDX_W-1:0] idx_reg,       idx_next;
    logic [CNT_W-1:0] bits_used_reg, bits_used_next;
    logic [RES_W-1:0] result_reg,    result_next;
    logic [RES_W-1:0] decided_reg,   decided_next;
    logic             busy_reg,      busy_next;
    logic             done_reg,      done_next;

    logic             cell_gt;
    logic             cell_lt;
    logic             cell_eq;
    logic [RES_W-1:0] cell_flags;

    comparator_1bit u_cell (
        .a  (a_sh_reg[WIDTH-1]),
        .b  (b_sh_reg[WIDTH-1]),
        .gt (cell_gt),
        .lt (cell_lt),
        .eq (cell_eq)
    );

    always_comb begin
        cell_flags         = '0;
        cell_flags[RES_GT] = cell_gt;
        cell_flags[RES_LT] = cell_lt;
    end

    always_comb begin
        state_next     = state_reg;
        a_sh_next      = a_sh_reg;
        b_sh_next      = b_sh_reg;
        idx_next       = idx_reg;
        bits_used_next = bits_used_reg;
        result_next    = result_reg;
        decided_next   = decided_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_sh_next      = bus.A;
                    b_sh_next      = bus.B;
                    idx_next       = IDX_MAX;
                    bits_used_next = '0;
                    result_next    = '0;
                    decided_next   = '0;
                    state_next     = COMPARE;
                end
            end
            COMPARE: begin
                bits_used_next = bits_used_reg + CNT_ONE;
                a_sh_next      = a_sh_reg << 1;
                b_sh_next      = b_sh_reg << 1;
                idx_next       = idx_reg - IDX_ONE;
                // Only the first difference matters; later bits cannot overturn it
                if ((decided_reg == '0) && !cell_eq) begin
                    decided_next = cell_flags;
                end
                if (EARLY_EXIT && !cell_eq) begin
                    result_next = cell_flags;
                    state_next  = DONE;
                end else if (idx_reg == '0) begin
                    if (decided_next != '0) begin
                        result_next = decided_next;
                    end else begin
                        result_next         = '0;
                        result_next[RES_EQ] = 1'b1;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            idx_reg       <= '0;
            bits_used_reg <= '0;
            result_reg    <= '0;
            decided_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_sh_reg      <= a_sh_next;
            b_sh_reg      <= b_sh_next;
            idx_reg       <= idx_next;
            bits_used_reg <= bits_used_next;
            result_reg    <= result_next;
            decided_reg   <= decided_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.A_greater_B = result_reg[RES_GT];
    assign bus.A_less_B    = result_reg[RES_LT];
    assign bus.A_equal_B   = result_reg[RES_EQ];
    assign bus.bits_used   = bits_used_reg;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Bench for serial_comparator_ctrl: an early-exit and a full-scan instance
// share stimulus; each completion is matched against a per-instance queue.
module tb_serial_comparator_ctrl;

    localparam int W = 8;
    localparam logic [2:0] F_GT = 3'b001;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b100;

    typedef struct {
        logic [2:0] flags;
        int         bits;
        int         done_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;
        int         bits_early;
        bit         disturb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q_e[$];
    exp_t q_f[$];
    vec_t vecs[9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_comparator_ctrl_if #(.WIDTH(W)) bus_e ();
    serial_comparator_ctrl_if #(.WIDTH(W)) bus_f ();

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e.slave)
    );

    serial_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f.slave)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic logic [2:0] flags_e();
        return {bus_e.A_equal_B, bus_e.A_less_B, bus_e.A_greater_B};
    endfunction

    function automatic logic [2:0] flags_f();
        return {bus_f.A_equal_B, bus_f.A_less_B, bus_f.A_greater_B};
    endfunction

    // Independent reference: scan from the MSB for the first differing bit
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [2:0] f, output int k);
        bit found = 0;
        f = F_EQ;
        k = W;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && a[i] != b[i]) begin
                found = 1;
                f = a[i] ? F_GT : F_LT;
                k = W - i;
            end
        end
    endfunction

    function automatic void mon(int which, logic d, logic [2:0] f, logic [3:0] bu);
        exp_t e;
        if (d !== 1'b1) return;
        if (which == 0) begin
            if (q_e.size() == 0) begin
                check("spurious_done_ee1", {31'b0, d}, 0);
                return;
            end
            e = q_e.pop_front();
        end else begin
            if (q_f.size() == 0) begin
                check("spurious_done_ee0", {31'b0, d}, 0);
                return;
            end
            e = q_f.pop_front();
        end
        check(which == 0 ? "flags_ee1" : "flags_ee0", {29'b0, f}, {29'b0, e.flags});
        check(which == 0 ? "bits_ee1" : "bits_ee0", {28'b0, bu}, e.bits);
        check(which == 0 ? "latency_ee1" : "latency_ee0", cyc, e.done_cyc);
        $display("done dut=%0d flags=%b bits_used=%0d cyc=%0d", which, f, bu, cyc);
    endfunction

    task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b);
        bus_e.start = s; bus_e.A = a; bus_e.B = b;
        bus_f.start = s; bus_f.A = a; bus_f.B = b;
    endtask

    task automatic check_clear(string tag);
        check({tag, "_busy"}, {30'b0, bus_e.busy, bus_f.busy}, 0);
        check({tag, "_done"}, {30'b0, bus_e.done, bus_f.done}, 0);
        check({tag, "_flags"}, {26'b0, flags_e(), flags_f()}, 0);
        check({tag, "_bits"}, {24'b0, bus_e.bits_used, bus_f.bits_used}, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus_e.busy || bus_f.busy) && t < 60) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   t = 0;
        wait_idle();
        drive(1'b1, v.a, v.b);
        e.flags = v.flags; e.bits = v.bits_early; e.done_cyc = cyc + 1 + v.bits_early;
        q_e.push_back(e);
        e.bits = W; e.done_cyc = cyc + 1 + W;
        q_f.push_back(e);
        $display("start A=%h B=%h exp_flags=%b bits_ee1=%0d disturb=%0d",
                 v.a, v.b, v.flags, v.bits_early, v.disturb);
        @(negedge clk);
        bus_e.start = 1'b0; bus_f.start = 1'b0;
        check("busy_after_accept", {30'b0, bus_e.busy, bus_f.busy}, 3);
        check("flags_cleared", {26'b0, flags_e(), flags_f()}, 0);
        while ((bus_e.busy || bus_f.busy) && t < 40) begin
            if (v.disturb) begin
                bus_e.A = 8'($urandom); bus_e.B = 8'($urandom);
                bus_f.A = bus_e.A;      bus_f.B = bus_e.B;
                bus_e.start = bus_e.busy && bus_f.busy;
                bus_f.start = bus_e.start;
            end
            @(negedge clk);
            t++;
        end
        bus_e.start = 1'b0; bus_f.start = 1'b0;
        check("busy_clears", {30'b0, bus_e.busy, bus_f.busy}, 0);
        check("pending_ee1", q_e.size(), 0);
        check("pending_ee0", q_f.size(), 0);
        q_e.delete(); q_f.delete();
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{8'h00, 8'h00, F_EQ, 8, 0};
        vecs[1] = '{8'h80, 8'h7F, F_GT, 1, 0};
        vecs[2] = '{8'h3C, 8'h3D, F_LT, 8, 0};
        vecs[3] = '{8'hA5, 8'h25, F_GT, 1, 1};
        vecs[4] = '{8'hFF, 8'hFF, F_EQ, 8, 0};
        vecs[5] = '{8'h01, 8'h00, F_GT, 8, 0};
        vecs[6] = '{8'h10, 8'h20, F_LT, 3, 0};
        vecs[7] = '{8'hC3, 8'hC7, F_LT, 6, 1};
        vecs[8] = '{8'h5A, 8'h5A, F_EQ, 8, 1};

        fork
            forever begin
                @(negedge clk);
                if (rst === 1'b0) begin
                    mon(0, bus_e.done, flags_e(), bus_e.bits_used);
                    mon(1, bus_f.done, flags_f(), bus_f.bits_used);
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, got t=%0t required <200000", $time);
                $fatal(1);
            end
        join_none

        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check_clear("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_clear("after_reset");

        foreach (vecs[i]) run(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            v.a = 8'($urandom); v.b = (i % 3 == 0) ? v.a : 8'($urandom);
            model(v.a, v.b, v.flags, v.bits_early);
            v.disturb = 0;
            run(v);
        end

        // Reset during the third COMPARE cycle: outputs clear at once, no done
        wait_idle();
        drive(1'b1, 8'h12, 8'h12);
        @(negedge clk);
        drive(1'b0, 8'h12, 8'h12);
        repeat (2) @(negedge clk);
        check("mid_busy_before_rst", {30'b0, bus_e.busy, bus_f.busy}, 3);
        #2 rst = 1'b1;
        #1 check_clear("async_rst");
        $display("reset asserted mid-compare at cyc=%0d", cyc);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_clear("post_rst_idle");
        v = '{8'hFF, 8'hFF, F_EQ, 8, 0};
        run(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_comparator_ctrl.md
# serial_comparator_ctrl

Sequencing controller that compares two WIDTH-bit unsigned operands one bit per clock, MSB first, by time-multiplexing a single instance of the team's 1-bit comparator cell. It sits between a requesting datapath (start/operand handshake) and the shared `comparator_1bit` cell. It registers a one-hot greater/less/equal result and optionally terminates early at the first differing bit.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits, legal range 1 to 32.
- `EARLY_EXIT`, 1: when 1, stop at the first differing bit; when 0, always scan all WIDTH bits.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  request strobe; sampled only in IDLE.
- `A`  input  WIDTH  operand A, captured on the accepting edge.
- `B`  input  WIDTH  operand B, captured on the accepting edge.
- `busy`  output  1  high in LOAD-accepted/COMPARE/DONE states (not IDLE).
- `done`  output  1  one-cycle pulse while in DONE.
- `A_greater_B`  output  1  registered result.
- `A_less_B`  output  1  registered result.
- `A_equal_B`  output  1  registered result.
- `bits_used`  output  $clog2(WIDTH+1)  number of bit positions evaluated for the last result.

## Operation
- States: IDLE, COMPARE, DONE, using a 2-bit encoding.
- Reset values:
  - state = IDLE.
  - All outputs are 0, including all three result flags. This means "no valid result".
  - Shift registers and the bit index are 0.
- IDLE:
  - If `start`=1 at an edge, capture `A`/`B` into shift registers, set the index to WIDTH-1, clear the result flags and `bits_used`, and go to COMPARE.
  - Otherwise stay in IDLE; results hold their last values.
- COMPARE, evaluated every edge:
  - Feed the current MSB of each shift register to the 1-bit cell.
  - Increment `bits_used`.
  - Shift both registers left by one and decrement the index.
- COMPARE exit conditions:
  - Cell reports greater or less, and EARLY_EXIT=1: latch that flag, go to DONE.
  - Cell reports greater or less, and EARLY_EXIT=0: record the first difference in a sticky "decided" register, ignore later bits, continue.
  - Index was 0 on this edge: latch the decided flag, or `A_equal_B` if no difference was seen, then go to DONE.
- DONE: `done`=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- `start` asserted outside IDLE is ignored and is not queued. Operands changing after capture have no effect.
- Exactly one result flag is high after any completed comparison.
- WIDTH=1: a single COMPARE cycle.

## Timing
- Edge E0 accepts `start`. Edges E1 through Ek perform the compares.
- `done` and the results are valid in the cycle after Ek.
- `busy` rises after E0 and falls after E(k+1).
- Value of k:
  - First differing bit at index i with EARLY_EXIT=1: k = WIDTH−i.
  - Otherwise: k = WIDTH.
- Back-to-back operation: the earliest next accept is the edge following the return to IDLE, giving a throughput of one compare per k+2 cycles.
- `rst` mid-operation: all outputs clear immediately (asynchronously) and no `done` is produced. The first legal `start` is on the first edge after `rst` deasserts.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `comparator_pkg` holds:
  - State encodings: IDLE=2'b00, COMPARE=2'b01, DONE=2'b10.
  - The result-flag index constants.
- Sub-module: one instance of `comparator_1bit`, driven by the shift-register MSBs. Its outputs are combinational into the FSM.
- Everything else (FSM, shift registers, index counter, `bits_used` counter, result registers) lives in this module.

## Test plan
All scenarios use WIDTH=8.
- Reset and idle:
  - Stimulus: assert `rst` for 3 cycles, then release.
  - Required: all outputs 0, `busy`=0. Pulse `start` with A=8'h00, B=8'h00: `A_equal_B`=1, `bits_used`=8, `done` in the cycle after E8.
- Early exit, EARLY_EXIT=1, greater:
  - Stimulus: A=8'h80, B=8'h7F.
  - Required: `A_greater_B`=1, `bits_used`=1, `done` one cycle after E1.
- Early exit, EARLY_EXIT=1, less at the LSB:
  - Stimulus: A=8'h3C, B=8'h3D.
  - Required: `A_less_B`=1, `bits_used`=8.
- Full scan, EARLY_EXIT=0:
  - Stimulus: A=8'hA5, B=8'h25.
  - Required: `A_greater_B`=1, `bits_used`=8. Toggling A/B during COMPARE does not change the result.
- Ignored start:
  - Stimulus: pulse `start` during COMPARE and during DONE.
  - Required: exactly one `done` pulse. Results reflect only the first operands.
- Reset mid-operation:
  - Stimulus: assert `rst` at cycle 3 of COMPARE.
  - Required: outputs clear in the same cycle, no `done` pulse. A subsequent start with A=8'hFF, B=8'hFF gives `A_equal_B`=1.
